// File: rtl/regfile_mp_pkg.sv
// Shared defaults and clear-FSM encodings for the multi-port integer register file.
package regfile_mp_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam int REG_DEPTH      = 32;

    typedef enum logic [1:0] {
        RF_IDLE  = 2'd0,
        RF_CLEAR = 2'd1,
        RF_DONE  = 2'd2
    } rf_state_e;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: zero register, same-cycle write bypass, range check, busy lookup.
module regfile_rdport
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_WIDTH,
    parameter int ADDR_W   = REG_ADDR_WIDTH,
    parameter int DEPTH    = REG_DEPTH,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic [DEPTH*DATA_W-1:0] entries,
    input  logic [DEPTH-1:0]        busy,
    input  logic                    byp_en,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [ADDR_W-1:0]       raddr,
    output logic [DATA_W-1:0]       rdata,
    output logic                    rbusy
);

    logic in_range;
    logic is_zero;

    assign in_range = ({1'b0, raddr} < (ADDR_W+1)'(DEPTH));
    assign is_zero  = (ZERO_REG != 0) && (raddr == '0);

    always_comb begin
        rdata = '0;
        rbusy = 1'b0;
        // Unmatched addresses (out of range) fall through with zero data and no busy.
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr == ADDR_W'(i) && !is_zero) begin
                rdata = entries[i*DATA_W +: DATA_W];
                rbusy = busy[i];
            end
        end
        // Busy is deliberately not bypassed: a release becomes visible next cycle.
        if ((BYPASS != 0) && byp_en && (waddr == raddr) && in_range && !is_zero) begin
            rdata = wdata;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write bypass, per-register busy scoreboard and sequential clear.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_WIDTH,
    parameter int ADDR_W   = REG_ADDR_WIDTH,
    parameter int DEPTH    = REG_DEPTH,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     clr_start,
    output logic                     ready,
    output logic                     clr_done,
    output rf_state_e                dbg_state
);

    localparam int CNT_W = ADDR_W + 1;

    // Handshake: we, iss_valid and clr_start are accepted only while the FSM is
    // IDLE; there is no backpressure, so anything presented while clearing is dropped.

    rf_state_e          state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               ready_q;
    logic               clr_done_q;
    logic               idle;

    logic [DATA_W-1:0]       mem [DEPTH];
    logic [DEPTH-1:0]        busy;
    logic [DEPTH-1:0]        wr_sel;
    logic [DEPTH-1:0]        set_sel;
    logic [DEPTH-1:0]        clr_sel;
    logic [DEPTH*DATA_W-1:0] entries_flat;
    logic                    byp_en;

    assign idle      = (state == RF_IDLE);
    assign ready     = ready_q;
    assign clr_done  = clr_done_q;
    assign dbg_state = state;
    assign byp_en    = we && ready_q && idle;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RF_IDLE: begin
                if (clr_start) begin
                    state_nxt = RF_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            RF_CLEAR: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_W'(DEPTH - 1)) begin
                    state_nxt = RF_DONE;
                end
            end
            RF_DONE: begin
                state_nxt = RF_IDLE;
            end
            default: begin
                state_nxt = RF_IDLE;
            end
        endcase
    end

    // ready and clr_done are registered off the current state, so each lags it by one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RF_IDLE;
            cnt        <= '0;
            ready_q    <= 1'b1;
            clr_done_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            ready_q    <= idle;
            clr_done_q <= (state == RF_DONE);
        end
    end

    always_comb begin
        wr_sel  = '0;
        set_sel = '0;
        clr_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (idle && we && (waddr == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
                wr_sel[i] = 1'b1;
            end
            if (idle && iss_valid && (iss_addr == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
                set_sel[i] = 1'b1;
            end
            if ((state == RF_CLEAR) && (cnt == CNT_W'(i))) begin
                clr_sel[i] = 1'b1;
            end
        end
    end

    // Issue marking beats writeback release when both hit the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (clr_sel[i]) begin
                    mem[i] <= '0;
                end else if (wr_sel[i]) begin
                    mem[i] <= wdata;
                end
                if (set_sel[i]) begin
                    busy[i] <= 1'b1;
                end else if (clr_sel[i] || wr_sel[i]) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        entries_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entries_flat[i*DATA_W +: DATA_W] = mem[i];
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_rdport #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .DEPTH   (DEPTH),
            .BYPASS  (BYPASS),
            .ZERO_REG(ZERO_REG)
        ) u_rd (
            .entries(entries_flat),
            .busy   (busy),
            .byp_en (byp_en),
            .waddr  (waddr),
            .wdata  (wdata),
            .raddr  (raddr[k*ADDR_W +: ADDR_W]),
            .rdata  (rdata[k*DATA_W +: DATA_W]),
            .rbusy  (rbusy[k])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default instance plus a no-bypass, 24-entry instance on shared inputs.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        clr_start;
    logic        clr_start_nb;

    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        ready;
    logic        clr_done;
    regfile_mp_pkg::rf_state_e dbg_state;

    logic [63:0] rdata_nb;
    logic [1:0]  rbusy_nb;
    logic        ready_nb;
    logic        clr_done_nb;
    regfile_mp_pkg::rf_state_e dbg_state_nb;

    int n_checks;
    int n_errors;
    logic [31:0] exp_q[$];

    regfile_mp dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .clr_start(clr_start),
        .ready(ready), .clr_done(clr_done), .dbg_state(dbg_state)
    );

    regfile_mp #(.DEPTH(24), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .clr_start(clr_start_nb),
        .ready(ready_nb), .clr_done(clr_done_nb), .dbg_state(dbg_state_nb)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // driver tasks: inputs change 1 time unit after posedge, checks happen at negedge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic set_raddr(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        int seen_done;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
        iss_valid = 1'b0; iss_addr = '0; clr_start = 1'b0; clr_start_nb = 1'b0;
        #2 rst = 1'b1;

        // reset state
        half();
        set_raddr(5'd5, 5'd9);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_clr_done", 32'(clr_done), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_rdata", rdata[31:0], 32'd0);
        check("rst_rbusy", 32'(rbusy), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // basic write / read, zero register on the other port
        set_raddr(5'd5, 5'd0);
        write_reg(5'd5, 32'hDEADBEEF);
        half();
        check("wr_x5_p0", rdata[31:0], 32'hDEADBEEF);
        check("wr_x5_p1_zero", rdata[63:32], 32'd0);
        check("wr_x5_nb", rdata_nb[31:0], 32'hDEADBEEF);
        tick();

        // x0 stays zero and never becomes busy, including on the bypass path
        set_raddr(5'd0, 5'd0);
        we = 1'b1; waddr = 5'd0; wdata = 32'h1234;
        iss_valid = 1'b1; iss_addr = 5'd0;
        half();
        check("x0_byp_p0", rdata[31:0], 32'd0);
        tick();
        we = 1'b0; iss_valid = 1'b0;
        half();
        check("x0_p0", rdata[31:0], 32'd0);
        check("x0_p1", rdata[63:32], 32'd0);
        check("x0_busy", 32'(rbusy), 32'd0);
        tick();

        // same-cycle bypass vs. no-bypass instance
        set_raddr(5'd5, 5'd7);
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
        half();
        check("byp_p1", rdata[63:32], 32'hA5A5A5A5);
        check("nobyp_p1_old", rdata_nb[63:32], 32'd0);
        check("byp_p0_other", rdata[31:0], 32'hDEADBEEF);
        tick();
        we = 1'b0;
        half();
        check("nobyp_p1_new", rdata_nb[63:32], 32'hA5A5A5A5);
        tick();

        // scoreboard: mark, release, set-wins
        set_raddr(5'd9, 5'd5);
        iss_valid = 1'b1; iss_addr = 5'd9;
        half();
        check("busy9_pre", 32'(rbusy[0]), 32'd0);
        tick();
        iss_valid = 1'b0;
        half();
        check("busy9_set", 32'(rbusy[0]), 32'd1);
        check("busy5_clear", 32'(rbusy[1]), 32'd0);
        tick();
        we = 1'b1; waddr = 5'd9; wdata = 32'd11;
        half();
        check("busy9_no_byp", 32'(rbusy[0]), 32'd1);
        tick();
        we = 1'b0;
        half();
        check("busy9_released", 32'(rbusy[0]), 32'd0);
        check("x9_11", rdata[31:0], 32'd11);
        tick();
        we = 1'b1; waddr = 5'd9; wdata = 32'd22;
        iss_valid = 1'b1; iss_addr = 5'd9;
        tick();
        we = 1'b0; iss_valid = 1'b0;
        half();
        check("busy9_set_wins", 32'(rbusy[0]), 32'd1);
        check("x9_22", rdata[31:0], 32'd22);
        tick();

        // out of range on the 24-entry instance
        set_raddr(5'd25, 5'd0);
        write_reg(5'd25, 32'd77);
        iss_valid = 1'b1; iss_addr = 5'd25;
        tick();
        iss_valid = 1'b0;
        half();
        check("x25_main", rdata[31:0], 32'd77);
        check("x25_nb_data", rdata_nb[31:0], 32'd0);
        check("x25_main_busy", 32'(rbusy[0]), 32'd1);
        check("x25_nb_busy", 32'(rbusy_nb[0]), 32'd0);
        tick();

        // fill x1..x31 with their index, then clear
        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), 32'(i));
        end
        set_raddr(5'd17, 5'd31);
        half();
        check("fill_x17", rdata[31:0], 32'd17);
        check("fill_x31", rdata[63:32], 32'd31);
        tick();

        set_raddr(5'd3, 5'd0);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        we = 1'b1; waddr = 5'd3; wdata = 32'hFFFF;
        for (int c = 1; c <= 34; c++) begin
            tick();
            if (c == 8) we = 1'b0;
            half();
            check($sformatf("clr_ready_c%0d", c), 32'(ready), (c >= 34) ? 32'd1 : 32'd0);
            check($sformatf("clr_done_c%0d", c), 32'(clr_done), (c == 33) ? 32'd1 : 32'd0);
            if (c == 3) check("clr_x3_no_byp", rdata[31:0], 32'd3);
            if (c == 5) check("clr_state", 32'(dbg_state), 32'd1);
        end
        tick();

        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(32'd0);
            exp_q.push_back(32'd0);
        end
        for (int i = 0; i < 32; i++) begin
            set_raddr(5'(i), 5'(31 - i));
            half();
            check($sformatf("cleared_p0_x%0d", i), rdata[31:0], exp_q.pop_front());
            check($sformatf("cleared_p1_x%0d", 31 - i), rdata[63:32], exp_q.pop_front());
            tick();
        end

        // reset mid-clear
        set_raddr(5'd20, 5'd0);
        write_reg(5'd20, 32'd20);
        iss_valid = 1'b1; iss_addr = 5'd20;
        tick();
        iss_valid = 1'b0;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
        end
        check("pre_rst_x20", rdata[31:0], 32'd20);
        check("pre_rst_busy20", 32'(rbusy[0]), 32'd1);
        check("pre_rst_ready", 32'(ready), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_mid_ready", 32'(ready), 32'd1);
        check("rst_mid_done", 32'(clr_done), 32'd0);
        check("rst_mid_state", 32'(dbg_state), 32'd0);
        check("rst_mid_x20", rdata[31:0], 32'd0);
        check("rst_mid_busy20", 32'(rbusy[0]), 32'd0);
        tick();
        rst = 1'b0;
        seen_done = 0;
        for (int c = 0; c < 40; c++) begin
            half();
            if (clr_done) seen_done++;
            tick();
        end
        check("rst_no_done_pulse", 32'(seen_done), 32'd0);
        half();
        check("post_rst_x20", rdata[31:0], 32'd0);
        check("post_rst_ready", 32'(ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file for the RV32I core; next generation of the single-port register file.
- Adds N configurable read ports, optional write-to-read bypass and a per-register busy scoreboard for pipelined hazard detection.
- Adds a sequential clear engine that zeroes the array one entry per cycle on request, for flush and soft restart.
- Sits between decode/issue (reads, busy marking) and writeback (writes, busy release).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width.
- DEPTH, 32, number of registers; must be at most 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = write data forwarded to a matching read port in the same cycle.
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- raddr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  read data, same packing as raddr.
- rbusy  out  NUM_RD  busy bit of each read port's addressed register.
- iss_valid  in  1  mark a register busy (an instruction was issued that targets it).
- iss_addr  in  ADDR_W  register to mark busy.
- clr_start  in  1  start the sequential clear.
- ready  out  1  high when IDLE; low while clearing.
- clr_done  out  1  one-cycle pulse when the clear completes.

Behaviour:
- Reset (rst high, asynchronous): all entries = 0, all busy bits = 0, FSM = IDLE, clear counter = 0, clr_done = 0, ready = 1.
- Reads are combinational, zero latency.
  - rdata[k] = 0 if ZERO_REG and raddr[k] == 0.
  - Else wdata if BYPASS, we, ready, waddr == raddr[k] and waddr is not the zero register.
  - Else the stored entry.
  - raddr[k] >= DEPTH: rdata = 0, rbusy = 0.
- Write: in IDLE with we = 1, entry[waddr] <= wdata at the rising edge and busy[waddr] <= 0.
  - Writes to register 0 are dropped when ZERO_REG = 1.
  - Writes with waddr >= DEPTH are dropped.
- Busy marking: in IDLE with iss_valid = 1, busy[iss_addr] <= 1.
  - Ignored for the zero register and for addresses >= DEPTH.
  - Same cycle, same address as a write: set wins, so busy ends at 1 and the data is still written.
- rbusy[k] = busy[raddr[k]], combinational.
  - No bypass on busy: a write in the current cycle releases busy only from the next cycle.
- FSM states:
  - IDLE to CLEAR on clr_start = 1. Counter = 0, ready drops the next cycle.
  - CLEAR: each cycle, entry[cnt] <= 0, busy[cnt] <= 0, cnt <= cnt + 1. we, iss_valid and clr_start are ignored.
  - CLEAR at cnt == DEPTH-1: clear that entry, go to DONE.
  - DONE: clr_done = 1 for exactly one cycle, then IDLE with ready = 1.
- Clear latency: clr_start sampled at edge 0, so CLEAR runs edges 1..DEPTH, clr_done is high after edge DEPTH+1, and ready is high again after edge DEPTH+2.
- clr_start held high in IDLE after DONE starts a new clear (level-sensitive in IDLE only).
- rst asserted mid-clear aborts immediately to the reset state. No clr_done pulse.
- Counter width = ADDR_W+1, so wrap is impossible when DEPTH = 2**ADDR_W.

Decomposition:
- Shared package/defines: REG_ADDR_WIDTH, REG_DATA_WIDTH, REG_DEPTH defaults; FSM state encodings RF_IDLE=2'd0, RF_CLEAR=2'd1, RF_DONE=2'd2.
- One natural sub-module, regfile_rdport: a single combinational read port (zero, bypass, range check, busy lookup), instantiated NUM_RD times in a generate loop.
- Storage, scoreboard and clear FSM stay in the top module.

Test Plan:
- Reset, then write x5 = 32'hDEADBEEF -> next cycle rdata[0] with raddr[0] = 5 reads 32'hDEADBEEF; rdata[1] with raddr[1] = 0 reads 0.
- Write x0 = 32'h1234 -> raddr = 0 reads 0 on every port; no busy bit set.
- BYPASS = 1: we, waddr = 7, wdata = 32'hA5A5A5A5 with raddr[1] = 7 in the same cycle -> rdata[1] = 32'hA5A5A5A5 before the edge. With BYPASS = 0 -> rdata[1] shows the old value.
- Scoreboard: iss_valid with iss_addr = 9 -> rbusy = 1 on the next cycle. Write x9 -> busy = 0 on the following cycle. iss_valid and we to x9 in the same cycle -> busy stays 1 and x9 holds the new data.
- Fill x1..x31 with their index, pulse clr_start -> ready low for DEPTH+1 cycles, clr_done high for 1 cycle at cycle DEPTH+1, all registers then read 0. A we to x3 during the clear is ignored.
- Assert rst at clear cycle 10 -> all outputs at reset values immediately, no clr_done pulse, x20 reads 0 after reset.
